// File: rtl/io_pwm_pkg.sv
// Shared types and constants for the PWM / static-pattern output stage.
package io_pwm_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_DUTY   = 1;
  localparam int REG_PERIOD = 2;
  localparam int REG_MASK   = 3;

  localparam int OUT_STROBE = 8;
  localparam int OUT_EN     = 9;
  localparam int OUT_HB     = 10;

  localparam int PRE_W   = 3;
  localparam int PRESC_W = 7;

  typedef struct packed {
    logic [1:0]       rsvd;
    logic             inv;
    logic [PRE_W-1:0] pre;
    logic             mode;
    logic             en;
  } ctrl_t;

  function automatic logic [7:0] reg_field(input logic [31:0] regs, input int idx);
    return regs[8*idx +: 8];
  endfunction

endpackage

// File: rtl/io_pwm_prescaler.sv
// Clock divider: one-cycle tick every 2^pre clocks, restartable via clear.
module io_pwm_prescaler
  import io_pwm_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] term;

  // Terminal count 2^pre - 1 built as a right-aligned run of ones.
  assign term = ~({PRESC_W{1'b1}} << pre);
  assign tick = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q + 7'd1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/io_pwm_driver.sv
// PWM / direct-pattern pin driver with shadowed register file.
// IO_PWM_GLITCHFREE_EN: shadows reload only at a period wrap or while disabled.
module io_pwm_driver
  import io_pwm_pkg::*;
#(
  parameter int REG_W   = 8,
  parameter int NUM_REG = 4,
  parameter int OUT_W   = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REG_W*NUM_REG-1:0] registers_packed,
  input  logic                     reg_valid,
  output logic [OUT_W-1:0]         data_out
);

  ctrl_t       ctrl_q, ctrl_d, ctrl_in;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  period_q, period_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hb_q, hb_d;
  logic [OUT_W-1:0] out_q, out_d;

  logic        tick, wrap, load, presc_clr, pwm;
  logic [7:0]  pins;
  logic        unused_rsvd;

  assign ctrl_in     = ctrl_t'(reg_field(registers_packed, REG_CTRL));
  // Reserved ctrl bits ride along in the shadow but drive nothing.
  assign unused_rsvd = ^ctrl_q.rsvd;

  assign wrap = ctrl_q.en && tick && (cnt_q == period_q);

`ifdef IO_PWM_GLITCHFREE_EN
  assign load      = reg_valid && (wrap || !ctrl_q.en);
  assign presc_clr = !ctrl_q.en || load;
`else
  assign load      = reg_valid;
  assign presc_clr = !ctrl_q.en || (load && (ctrl_in.pre != ctrl_q.pre));
`endif

  io_pwm_prescaler u_presc (
    .clock (clock),
    .reset (reset),
    .clear (presc_clr),
    .pre   (ctrl_q.pre),
    .tick  (tick)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    duty_d   = duty_q;
    period_d = period_q;
    mask_d   = mask_q;
    if (load) begin
      ctrl_d   = ctrl_in;
      duty_d   = reg_field(registers_packed, REG_DUTY);
      period_d = reg_field(registers_packed, REG_PERIOD);
      mask_d   = reg_field(registers_packed, REG_MASK);
    end

    cnt_d = cnt_q;
    hb_d  = hb_q;
    if (!ctrl_q.en) begin
      cnt_d = '0;
      hb_d  = 1'b0;
    end else if (tick) begin
      cnt_d = (cnt_q == period_q) ? 8'd0 : cnt_q + 8'd1;
      if (wrap) hb_d = ~hb_q;
    end

    // duty > period keeps pwm high for the whole period; duty == 0 keeps it low.
    pwm  = (cnt_q < duty_q);
    pins = ctrl_q.mode ? mask_q : (mask_q & {8{pwm}});
    pins = pins ^ {8{ctrl_q.inv}};

    out_d = '0;
    if (ctrl_q.en) begin
      out_d[7:0]        = pins;
      out_d[OUT_STROBE] = wrap;
      out_d[OUT_EN]     = 1'b1;
      out_d[OUT_HB]     = hb_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      hb_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      hb_q     <= hb_d;
      out_q    <= out_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: tb/tb_io_pwm_driver.sv
// Directed bench for io_pwm_driver; expectations are queued per cycle and checked by a monitor.
module tb_io_pwm_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic        reg_valid;
  logic [31:0] registers_packed;
  logic [10:0] data_out;

  always #5 clock = ~clock;

  io_pwm_driver dut (
    .clock            (clock),
    .reset            (reset),
    .registers_packed (registers_packed),
    .reg_valid        (reg_valid),
    .data_out         (data_out)
  );

  typedef struct {
    int          cyc;
    logic [10:0] mask;
    logic [10:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: data_out is meaningful every cycle; compare any entry due now.
  always begin
    exp_t e;
    @(posedge clock);
    #2;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
      end else if ((data_out & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: cyc=%0d data_out=%h expected=%h (mask %h)",
                 e.name, cyc, data_out, e.val, e.mask);
      end
    end
  end

  function automatic logic [31:0] pack(input logic [7:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic expect_at(input int c, input logic [10:0] m, input logic [10:0] v,
                           input string nm);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Reset for one edge with the new registers applied; first active output at t0.
  task automatic start_run(input logic [31:0] regs, output int t0);
    @(negedge clock);
    reset            = 1'b1;
    reg_valid        = 1'b1;
    registers_packed = regs;
    expect_at(cyc + 1, 11'h7FF, 11'h000, "reset_out");
    @(negedge clock);
    reset = 1'b0;
    expect_at(cyc + 1, 11'h7FF, 11'h000, "first_load");
    t0 = cyc + 2;
  endtask

  // R0=01 duty=3 period=9 mask=FF: 3 high, 7 low, strobe at cnt 9, hb toggles per period.
  task automatic queue_pwm(input int t0, input int n, input string nm);
    int c, p;
    for (int i = 0; i < n; i++) begin
      c = i % 10;
      p = i / 10;
      expect_at(t0 + i, 11'h7FF,
                {((p % 2) == 1), 1'b1, (c == 9), (c < 3) ? 8'hFF : 8'h00}, nm);
    end
  endtask

  initial begin
    int t0;
    int c;
    logic [7:0] lo;

    reset            = 1'b1;
    reg_valid        = 1'b0;
    registers_packed = '0;

    // Basic PWM
    start_run(pack(8'h01, 8'd3, 8'd9, 8'hFF), t0);
    queue_pwm(t0, 25, "pwm");
    wait_to(t0 + 24);

    // Reset mid-period with random registers, then restart from cnt 0
    reset            = 1'b1;
    registers_packed = $urandom;
    reg_valid        = 1'($urandom_range(0, 1));
    expect_at(cyc + 1, 11'h7FF, 11'h000, "reset_mid");
    start_run(pack(8'h01, 8'd3, 8'd9, 8'hFF), t0);
    queue_pwm(t0, 12, "pwm_restart");
    wait_to(t0 + 11);

    // Prescale by 8 with inversion: F0 / FF levels of 8 clocks each
    start_run(pack(8'h2D, 8'd1, 8'd1, 8'h0F), t0);
    for (int i = 0; i < 32; i++)
      expect_at(t0 + i, 11'h3FF,
                {1'b0, 1'b1, ((i % 16) == 15), (((i / 8) % 2) == 1) ? 8'hFF : 8'hF0},
                "prescale_inv");
    wait_to(t0 + 31);

    // duty=0: constant low
    start_run(pack(8'h01, 8'd0, 8'd9, 8'hFF), t0);
    for (int i = 0; i < 20; i++) expect_at(t0 + i, 11'h0FF, 11'h000, "duty_zero");
    wait_to(t0 + 19);

    // duty > period: constant mask
    start_run(pack(8'h01, 8'hFF, 8'hFE, 8'h5A), t0);
    for (int i = 0; i < 30; i++) expect_at(t0 + i, 11'h1FF, 11'h05A, "duty_gt_period");
    wait_to(t0 + 29);

    // period=0: high, strobe every tick, heartbeat toggling every clock
    start_run(pack(8'h01, 8'd1, 8'd0, 8'hFF), t0);
    for (int i = 0; i < 8; i++)
      expect_at(t0 + i, 11'h7FF, {((i % 2) == 1), 1'b1, 1'b1, 8'hFF}, "period_zero");
    wait_to(t0 + 7);

    // Duty rewrite 50 -> 10 so that the new value would apply at cnt 20
    start_run(pack(8'h01, 8'd50, 8'd99, 8'hFF), t0);
    for (int i = 0; i < 116; i++) begin
`ifdef IO_PWM_GLITCHFREE_EN
      lo = (i < 50 || (i >= 100 && i < 110)) ? 8'hFF : 8'h00;
`else
      lo = (i < 20 || (i >= 100 && i < 110)) ? 8'hFF : 8'h00;
`endif
      expect_at(t0 + i, 11'h1FF, {2'b00, (i == 99), lo}, "duty_rewrite");
    end
    wait_to(t0 + 18);
    registers_packed = pack(8'h01, 8'd10, 8'd99, 8'hFF);
    wait_to(t0 + 115);

    // reg_valid gating of a mask change
    start_run(pack(8'h01, 8'd3, 8'd9, 8'hFF), t0);
    for (int i = 0; i < 50; i++) begin
      c = i % 10;
      lo = (c < 3) ? ((i >= 40) ? 8'h0F : 8'hFF) : 8'h00;
      expect_at(t0 + i, 11'h3FF, {2'b01, (c == 9), lo}, "reg_valid_gate");
    end
    wait_to(t0 + 2);
    reg_valid        = 1'b0;
    registers_packed = pack(8'h01, 8'd3, 8'd9, 8'h0F);
    wait_to(t0 + 32);
    reg_valid = 1'b1;
    wait_to(t0 + 49);

    // Direct mode pattern, then disable with INV set: all pins low
    start_run(pack(8'h03, 8'd0, 8'd9, 8'hA5), t0);
    for (int i = 0; i < 12; i++)
      expect_at(t0 + i, 11'h3FF, {2'b01, ((i % 10) == 9), 8'hA5}, "direct");
    for (int i = 22; i < 26; i++) expect_at(t0 + i, 11'h7FF, 11'h000, "disabled");
    wait_to(t0 + 11);
    registers_packed = pack(8'h20, 8'd0, 8'd9, 8'hA5);
    wait_to(t0 + 27);

    repeat (3) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
